ext_call_sequencer: RTL

- Upstream stimulus/sequencing stage for a foreign-call test module.
- Counts cycles and issues a fixed number of indexed call requests to the downstream module over a valid/ready handshake.
- Collects each response, compares it against an expected value, and reports the pass/fail and done status that the bench uses to end the run.

---
 rtl/ext_call_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ext_call_sequencer.sv
// Stimulus sequencer for a foreign-call test module: issues NUM_CALLS indexed requests,
// checks each response against exp_data and reports done/pass. Optional trace: EXT_TRACE_EN.
module ext_call_sequencer #(
    parameter int DW        = 9,
    parameter int NUM_CALLS = 4,
    parameter int START_DLY = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          req_valid,
    output logic [7:0]    req_idx,
    input  logic          req_ready,
    input  logic          rsp_valid,
    input  logic [DW-1:0] rsp_data,
    input  logic [DW-1:0] exp_data,
    output logic [7:0]    cyc,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic          timeout_err
);

    // state    | meaning
    // S_IDLE   | waiting for start after reset
    // S_DELAY  | counting START_DLY idle cycles
    // S_ISSUE  | req_valid high until req_ready
    // S_WAIT   | waiting for rsp_valid or timeout
    // S_DONE   | run finished, results held until next start
    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] DLY_INIT = 8'(START_DLY);
    localparam logic [7:0] TMO_INIT = 8'(TIMEOUT);
    localparam logic [7:0] LAST_IDX = 8'(NUM_CALLS - 1);

    state_t     state_q, state_d;
    logic [7:0] cyc_q, cyc_d;
    logic [7:0] dly_q, dly_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] err_q, err_d;
    logic       tmo_err_q, tmo_err_d;
    logic       call_end;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q + 8'd1;
        dly_d     = dly_q;
        tmo_d     = tmo_q;
        idx_d     = idx_q;
        err_d     = err_q;
        tmo_err_d = tmo_err_q;
        call_end  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d     = 8'd0;
                    tmo_err_d = 1'b0;
                    idx_d     = 8'd0;
                    dly_d     = DLY_INIT;
                    state_d   = (START_DLY == 0) ? S_ISSUE : S_DELAY;
                end
            end
            S_DELAY: begin
                dly_d = dly_q - 8'd1;
                if (dly_q <= 8'd1) begin
                    dly_d   = 8'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    tmo_d   = TMO_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // a response on the expiring cycle wins over the timeout
                if (rsp_valid) begin
                    call_end = 1'b1;
                    if ((rsp_data != exp_data) && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'd1;
                    end
                end else if (tmo_q <= 8'd1) begin
                    tmo_d     = 8'd0;
                    tmo_err_d = 1'b1;
                    call_end  = 1'b1;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
                if (call_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cyc_q     <= 8'd0;
            dly_q     <= 8'd0;
            tmo_q     <= 8'd0;
            idx_q     <= 8'd0;
            err_q     <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            dly_q     <= dly_d;
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

`ifdef EXT_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == S_WAIT && rsp_valid) begin
                $display("[%0d] call %0d got/exp %0h/%0h", cyc_q, idx_q, rsp_data, exp_data);
            end else if (state_q == S_WAIT && tmo_q <= 8'd1) begin
                $display("[%0d] call %0d TIMEOUT", cyc_q, idx_q);
            end
            if (state_q != S_DONE && state_d == S_DONE) begin
                if (err_d == 8'd0 && !tmo_err_d) $display("*-* All Finished *-*");
                else $display("%%Error: %0d mismatches", err_d);
            end
        end
    end
`endif

    assign req_valid   = (state_q == S_ISSUE);
    assign req_idx     = idx_q;
    assign cyc         = cyc_q;
    assign busy        = (state_q == S_DELAY) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);
    assign pass        = done && (err_q == 8'd0) && !tmo_err_q;
    assign err_count   = err_q;
    assign timeout_err = tmo_err_q;

endmodule
